// File: rtl/mcash_tracer_pkg.sv
// Shared record type, widths and small arithmetic helpers for the
// crossbar request tracer and its per-channel capture FIFOs.
package mcash_tracer_pkg;

    localparam int OP_W       = 3;
    localparam int DROP_CNT_W = 16;
    localparam int SEQ_W      = 32;

    // Record fields are sized for the widest supported build (8 channels,
    // 64-bit address, 128-bit data); narrower builds zero-extend into them.
    localparam int REC_CH_W   = 3;
    localparam int REC_ADDR_W = 64;
    localparam int REC_DATA_W = 128;

    typedef struct packed {
        logic [REC_CH_W-1:0]   ch;
        logic [OP_W-1:0]       op;
        logic [REC_ADDR_W-1:0] addr;
        logic [REC_DATA_W-1:0] data;
    } trace_rec_t;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

    function automatic logic [DROP_CNT_W-1:0] sat_add_drop(
        input logic [DROP_CNT_W-1:0] cnt,
        input logic [3:0]            inc
    );
        logic [DROP_CNT_W:0] sum;
        sum = {1'b0, cnt} + {{(DROP_CNT_W - 3){1'b0}}, inc};
        return sum[DROP_CNT_W] ? {DROP_CNT_W{1'b1}} : sum[DROP_CNT_W-1:0];
    endfunction

endpackage

// File: rtl/mcash_sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; a push into a full FIFO is
// accepted when a pop happens on the same edge.
module mcash_sync_fifo #(
    parameter int  WIDTH = 8,
    parameter int  DEPTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign do_push = push_i & (~full_o | pop_i);
    assign do_pop  = pop_i & ~empty_o;

    assign wr_ptr_d = do_push ? wr_ptr_q + (AW + 1)'(1) : wr_ptr_q;
    assign rd_ptr_d = do_pop  ? rd_ptr_q + (AW + 1)'(1) : rd_ptr_q;

    assign dout_o = mem_q[rd_ptr_q[AW-1:0]];

    // NOTE: non-blocking (<=) in clocked blocks so every register samples
    // the pre-edge values of its sources.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // NOTE: storage is deliberately not reset; the pointers alone define
    // which entries are valid, and unreset arrays map onto plain RAM.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= din_i;
        end
    end

endmodule

// File: rtl/mcash_xbar_req_tracer.sv
// Snoops accepted crossbar requests on every channel, queues them per channel
// and presents them one at a time, round-robin, with a sequence number.
module mcash_xbar_req_tracer
    import mcash_tracer_pkg::*;
#(
    parameter int  NUM_CH   = 4,
    parameter int  DEPTH    = 8,
    parameter int  ADDR_W   = 32,
    parameter int  DATA_W   = 64,
    parameter int  LINE_OFF = 4,
    localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     trace_en_i,
    input  logic [NUM_CH-1:0]        ch_req_valid_i,
    input  logic [NUM_CH-1:0]        ch_req_allowIn_i,
    input  logic [NUM_CH*OP_W-1:0]   ch_req_op_i,
    input  logic [NUM_CH*ADDR_W-1:0] ch_req_addr_i,
    input  logic [NUM_CH*DATA_W-1:0] ch_req_data_i,
    output logic                     trace_valid_o,
    input  logic                     trace_ready_i,
    output logic [CH_W-1:0]          trace_ch_o,
    output logic [OP_W-1:0]          trace_op_o,
    output logic [ADDR_W-1:0]        trace_addr_o,
    output logic [DATA_W-1:0]        trace_data_o,
    output logic [SEQ_W-1:0]         trace_seq_o,
    output logic [NUM_CH-1:0]        ovf_o,
    output logic [DROP_CNT_W-1:0]    drop_cnt_o
);

    localparam int                PAY_W     = OP_W + ADDR_W + DATA_W;
    localparam logic [ADDR_W-1:0] LINE_MASK = {ADDR_W{1'b1}} << LINE_OFF;
    localparam logic [CH_W:0]     NUM_CH_W  = (CH_W + 1)'(NUM_CH);
    localparam logic [CH_W-1:0]   LAST_CH   = CH_W'(NUM_CH - 1);

    logic [NUM_CH-1:0] cap;
    logic [NUM_CH-1:0] push;
    logic [NUM_CH-1:0] pop;
    logic [NUM_CH-1:0] drop;
    logic [NUM_CH-1:0] full;
    logic [NUM_CH-1:0] empty;
    logic [PAY_W-1:0]  din  [NUM_CH];
    logic [PAY_W-1:0]  dout [NUM_CH];

    logic [CH_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [CH_W-1:0]       grant;
    logic                  grant_vld;
    logic                  load;
    logic                  do_load;
    logic [PAY_W-1:0]      sel_pay;
    trace_rec_t            out_q, out_d;
    logic                  out_valid_q, out_valid_d;
    logic [SEQ_W-1:0]      seq_q, seq_d;
    logic [SEQ_W-1:0]      seq_cnt_q, seq_cnt_d;
    logic [NUM_CH-1:0]     ovf_q, ovf_d;
    logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        assign cap[k]  = ch_req_valid_i[k] & ch_req_allowIn_i[k] & trace_en_i;
        // A full FIFO still takes the capture if the output stage pops it this edge.
        assign push[k] = cap[k] & (~full[k] | pop[k]);
        assign drop[k] = cap[k] & full[k] & ~pop[k];
        assign pop[k]  = do_load & (grant == CH_W'(k));
        assign din[k]  = {ch_req_op_i[k*OP_W +: OP_W],
                          ch_req_addr_i[k*ADDR_W +: ADDR_W] & LINE_MASK,
                          ch_req_data_i[k*DATA_W +: DATA_W]};

        mcash_sync_fifo #(
            .WIDTH (PAY_W),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk     (clk),
            .rst     (rst),
            .push_i  (push[k]),
            .din_i   (din[k]),
            .pop_i   (pop[k]),
            .dout_o  (dout[k]),
            .full_o  (full[k]),
            .empty_o (empty[k])
        );
    end

    // Walk channels from the far end of the round-robin order back towards the
    // pointer so the last hit is the first non-empty channel after it.
    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        logic [CH_W:0] idx;
        grant_vld = 1'b0;
        grant     = '0;
        idx       = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            idx = {1'b0, rr_ptr_q} + (CH_W + 1)'(i);
            if (idx >= NUM_CH_W) begin
                idx = idx - NUM_CH_W;
            end
            if (!empty[idx[CH_W-1:0]]) begin
                grant_vld = 1'b1;
                grant     = idx[CH_W-1:0];
            end
        end
    end

    assign load    = ~out_valid_q | trace_ready_i;
    assign do_load = load & grant_vld;
    assign sel_pay = dout[grant];

    always_comb begin
        out_d       = out_q;
        out_valid_d = out_valid_q;
        seq_d       = seq_q;
        seq_cnt_d   = seq_cnt_q;
        rr_ptr_d    = rr_ptr_q;
        if (load) begin
            out_valid_d = grant_vld;
        end
        if (do_load) begin
            out_d.ch   = REC_CH_W'(grant);
            out_d.op   = sel_pay[PAY_W-1 -: OP_W];
            out_d.addr = REC_ADDR_W'(sel_pay[DATA_W +: ADDR_W]);
            out_d.data = REC_DATA_W'(sel_pay[DATA_W-1:0]);
            seq_d      = seq_cnt_q;
            seq_cnt_d  = seq_cnt_q + SEQ_W'(1);
            rr_ptr_d   = (grant == LAST_CH) ? '0 : grant + CH_W'(1);
        end
    end

    assign ovf_d      = ovf_q | drop;
    assign drop_cnt_d = sat_add_drop(drop_cnt_q, popcount8(8'(drop)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
            seq_q       <= '0;
            seq_cnt_q   <= '0;
            rr_ptr_q    <= '0;
            ovf_q       <= '0;
            drop_cnt_q  <= '0;
        end else begin
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            seq_q       <= seq_d;
            seq_cnt_q   <= seq_cnt_d;
            rr_ptr_q    <= rr_ptr_d;
            ovf_q       <= ovf_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign trace_valid_o = out_valid_q;
    assign trace_ch_o    = out_q.ch[CH_W-1:0];
    assign trace_op_o    = out_q.op;
    assign trace_addr_o  = out_q.addr[ADDR_W-1:0];
    assign trace_data_o  = out_q.data[DATA_W-1:0];
    assign trace_seq_o   = seq_q;
    assign ovf_o         = ovf_q;
    assign drop_cnt_o    = drop_cnt_q;

    // Upper record bits only exist for wider builds.
    logic unused_rec_bits;
    assign unused_rec_bits = ^out_q;

endmodule

// File: tb/tb_mcash_xbar_req_tracer.sv
// Directed bench for the crossbar request tracer: reset, latency, ordering,
// overflow and saturation, stall stability, sequence wrap and mid-run reset.
module tb_mcash_xbar_req_tracer;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         trace_en = 1'b0;
    logic         trace_ready = 1'b0;
    logic [3:0]   req_valid = '0;
    logic [3:0]   req_allow = '0;
    logic [11:0]  req_op = '0;
    logic [127:0] req_addr = '0;
    logic [255:0] req_data = '0;

    logic         trace_valid;
    logic [1:0]   trace_ch;
    logic [2:0]   trace_op;
    logic [31:0]  trace_addr;
    logic [63:0]  trace_data;
    logic [31:0]  trace_seq;
    logic [3:0]   ovf;
    logic [15:0]  drop_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    mcash_xbar_req_tracer #(
        .NUM_CH   (4),
        .DEPTH    (8),
        .ADDR_W   (32),
        .DATA_W   (64),
        .LINE_OFF (4)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .trace_en_i       (trace_en),
        .ch_req_valid_i   (req_valid),
        .ch_req_allowIn_i (req_allow),
        .ch_req_op_i      (req_op),
        .ch_req_addr_i    (req_addr),
        .ch_req_data_i    (req_data),
        .trace_valid_o    (trace_valid),
        .trace_ready_i    (trace_ready),
        .trace_ch_o       (trace_ch),
        .trace_op_o       (trace_op),
        .trace_addr_o     (trace_addr),
        .trace_data_o     (trace_data),
        .trace_seq_o      (trace_seq),
        .ovf_o            (ovf),
        .drop_cnt_o       (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int k, input logic [2:0] op, input logic [31:0] addr,
                         input logic [63:0] data);
        req_valid[k]          = 1'b1;
        req_allow[k]          = 1'b1;
        req_op[k*3 +: 3]      = op;
        req_addr[k*32 +: 32]  = addr;
        req_data[k*64 +: 64]  = data;
    endtask

    task automatic idle();
        req_valid = '0;
        req_allow = '0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        prev_v;
        logic        prev_rdy;
        logic [1:0]  p_ch;
        logic [2:0]  p_op;
        logic [31:0] p_addr;
        logic [63:0] p_data;
        logic [31:0] p_seq;
        int          got;
        int          exp_seq;
        int          nxt0;
        int          nxt1;

        // Reset values while rst is held high.
        tick();
        tick();
        check("rst_valid", trace_valid, 0);
        check("rst_ch",    trace_ch,    0);
        check("rst_op",    trace_op,    0);
        check("rst_addr",  trace_addr,  0);
        check("rst_data",  trace_data,  0);
        check("rst_seq",   trace_seq,   0);
        check("rst_ovf",   ovf,         0);
        check("rst_drop",  drop_cnt,    0);
        rst = 1'b0;

        // Single capture on ch2: line offset cleared, valid after the second edge.
        trace_en    = 1'b1;
        trace_ready = 1'b1;
        drive(2, 3'd3, 32'h1234_5678, 64'hDEAD);
        tick();
        idle();
        check("single_not_yet", trace_valid, 0);
        tick();
        check("single_valid", trace_valid, 1);
        check("single_ch",    trace_ch,    2);
        check("single_op",    trace_op,    3);
        check("single_addr",  trace_addr,  32'h1234_5670);
        check("single_data",  trace_data,  64'hDEAD);
        check("single_seq",   trace_seq,   0);
        tick();
        check("single_consumed", trace_valid, 0);

        // No capture with trace_en low or without allowIn.
        trace_en = 1'b0;
        drive(0, 3'd1, 32'h40, 64'h1);
        tick();
        tick();
        check("en_low_no_capture", trace_valid, 0);
        trace_en = 1'b1;
        req_allow = '0;
        tick();
        tick();
        check("allow_low_no_capture", trace_valid, 0);
        idle();

        // Same-edge captures on all channels emerge in channel order, back to back.
        do_reset();
        trace_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            drive(k, 3'(k), 32'h1000 * (k + 1) + 32'hF, 64'h100 + 64'(k));
        end
        tick();
        idle();
        for (int k = 0; k < 4; k++) begin
            tick();
            check("burst_valid", trace_valid, 1);
            check("burst_ch",    trace_ch,    k);
            check("burst_addr",  trace_addr,  32'h1000 * (k + 1));
            check("burst_seq",   trace_seq,   k);
        end

        // Round-robin resumes after the last grant: ch0 granted, then ch2 beats ch0.
        drive(0, 3'd0, 32'h5000, 64'h50);
        tick();
        drive(0, 3'd0, 32'h6000, 64'h60);
        drive(2, 3'd2, 32'h7000, 64'h70);
        tick();
        idle();
        check("rr_first_ch",   trace_ch,   0);
        check("rr_first_data", trace_data, 64'h50);
        check("rr_first_seq",  trace_seq,  4);
        tick();
        check("rr_second_ch",   trace_ch,   2);
        check("rr_second_data", trace_data, 64'h70);
        check("rr_second_seq",  trace_seq,  5);
        tick();
        check("rr_third_ch",   trace_ch,   0);
        check("rr_third_data", trace_data, 64'h60);
        check("rr_third_seq",  trace_seq,  6);
        tick();
        check("rr_drained", trace_valid, 0);

        // Stalled output, 10 captures on ch1: 1 presented, 8 queued, 1 dropped.
        do_reset();
        trace_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            drive(1, 3'd1, 32'h100 * (i + 1) + 32'h3, 64'(i));
            tick();
        end
        idle();
        check("ovf_flag",  ovf,         4'b0010);
        check("ovf_drop",  drop_cnt,    1);
        check("ovf_valid", trace_valid, 1);
        check("ovf_ch",    trace_ch,    1);
        check("ovf_addr",  trace_addr,  32'h100);
        check("ovf_seq",   trace_seq,   0);
        tick();
        check("ovf_hold_data", trace_data, 0);
        check("ovf_hold_drop", drop_cnt,   1);
        trace_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            check("drain_valid", trace_valid, 1);
            check("drain_addr",  trace_addr,  32'h100 * (i + 1));
            check("drain_data",  trace_data,  64'(i));
            check("drain_seq",   trace_seq,   i);
            tick();
        end
        check("drain_empty",  trace_valid, 0);
        check("drain_sticky", ovf,         4'b0010);

        // Multi-channel same-edge drops and counter saturation.
        do_reset();
        trace_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drive(k, 3'd7, 32'h8000 + 32'(k), 64'(k));
        end
        for (int n = 0; n < 9; n++) tick();
        check("multi_drop_3",   drop_cnt, 3);
        check("multi_ovf_1110", ovf,      4'b1110);
        tick();
        check("multi_drop_7",   drop_cnt, 7);
        check("multi_ovf_1111", ovf,      4'b1111);
        for (int n = 0; n < 16400; n++) tick();
        check("sat_drop", drop_cnt, 16'hFFFF);
        tick();
        check("sat_hold", drop_cnt, 16'hFFFF);
        check("sat_out_ch",  trace_ch,  0);
        check("sat_out_seq", trace_seq, 0);

        // Asynchronous reset with records queued clears everything at once.
        idle();
        rst = 1'b1;
        #1;
        check("arst_valid", trace_valid, 0);
        check("arst_ovf",   ovf,         0);
        check("arst_drop",  drop_cnt,    0);
        check("arst_seq",   trace_seq,   0);
        tick();
        rst = 1'b0;
        trace_ready = 1'b1;
        drive(3, 3'd5, 32'hABCD_EF0F, 64'h33);
        tick();
        idle();
        tick();
        check("arst_next_valid", trace_valid, 1);
        check("arst_next_ch",    trace_ch,    3);
        check("arst_next_addr",  trace_addr,  32'hABCD_EF00);
        check("arst_next_seq",   trace_seq,   0);
        tick();

        // Ready toggling with ch0+ch1 traffic: stable while stalled, nothing lost.
        do_reset();
        prev_v   = 1'b0;
        prev_rdy = 1'b1;
        p_ch = '0; p_op = '0; p_addr = '0; p_data = '0; p_seq = '0;
        got = 0; exp_seq = 0; nxt0 = 0; nxt1 = 0;
        for (int c = 0; c < 40; c++) begin
            if (c < 6) begin
                drive(0, 3'd2, 32'h2000 + 32'(c * 16), 64'(c));
                drive(1, 3'd4, 32'h3000 + 32'(c * 16), 64'h100 + 64'(c));
            end else begin
                idle();
            end
            trace_ready = (c % 2 == 1);
            if (prev_v && !prev_rdy) begin
                check("stall_valid", trace_valid, 1);
                check("stall_ch",    trace_ch,    p_ch);
                check("stall_op",    trace_op,    p_op);
                check("stall_addr",  trace_addr,  p_addr);
                check("stall_data",  trace_data,  p_data);
                check("stall_seq",   trace_seq,   p_seq);
            end
            if (trace_valid && trace_ready) begin
                check("toggle_seq", trace_seq, exp_seq);
                if (trace_ch == 2'd0) begin
                    check("toggle_ch0_data", trace_data, 64'(nxt0));
                    nxt0++;
                end else begin
                    check("toggle_ch1_data", trace_data, 64'h100 + 64'(nxt1));
                    nxt1++;
                end
                exp_seq++;
                got++;
            end
            prev_v   = trace_valid;
            prev_rdy = trace_ready;
            p_ch = trace_ch; p_op = trace_op; p_addr = trace_addr;
            p_data = trace_data; p_seq = trace_seq;
            tick();
        end
        check("toggle_count", got,         12);
        check("toggle_drop",  drop_cnt,    0);
        check("toggle_ovf",   ovf,         0);
        check("toggle_idle",  trace_valid, 0);

        // Sequence number wraps from 0xFFFFFFFF to 0.
        do_reset();
        trace_ready = 1'b1;
        force dut.seq_cnt_q = 32'hFFFF_FFFF;
        drive(0, 3'd1, 32'h9000, 64'hA0);
        drive(1, 3'd1, 32'h9100, 64'hA1);
        tick();
        release dut.seq_cnt_q;
        idle();
        tick();
        check("wrap_seq_max", trace_seq, 32'hFFFF_FFFF);
        check("wrap_ch0",     trace_ch,  0);
        tick();
        check("wrap_seq_zero", trace_seq, 0);
        check("wrap_ch1",      trace_ch,  1);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mcash_xbar_req_tracer.md
MCASH_XBAR_REQ_TRACER -- requirements
Module: mcash_xbar_req_tracer

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of crossbar request channels snooped (1..8).
REQ-002 SHALL have parameter DEPTH, default 8: entries per channel capture FIFO (power of two, >=2).
REQ-003 SHALL have parameter ADDR_W, default 32: request address width.
REQ-004 SHALL have parameter DATA_W, default 64: request data width.
REQ-005 SHALL have parameter LINE_OFF, default 4: low address bits cleared on capture.
REQ-006 SHALL have port clk  input  1  the single clock; all logic on posedge.
REQ-007 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-008 SHALL have port trace_en_i  input  1  capture enable; 0 = no new captures, draining continues.
REQ-009 SHALL have port ch_req_valid_i  input  NUM_CH  per-channel request valid.
REQ-010 SHALL have port ch_req_allowIn_i  input  NUM_CH  per-channel request accept.
REQ-011 SHALL have port ch_req_op_i  input  NUM_CH*3  per-channel op; channel k is bits [3k+2:3k].
REQ-012 SHALL have port ch_req_addr_i  input  NUM_CH*ADDR_W  per-channel address, packed the same way.
REQ-013 SHALL have port ch_req_data_i  input  NUM_CH*DATA_W  per-channel data, packed the same way.
REQ-014 SHALL have port trace_valid_o  output  1  trace record valid.
REQ-015 SHALL have port trace_ready_i  input  1  consumer accepts record.
REQ-016 SHALL have port trace_ch_o  output  $clog2(NUM_CH) (min 1)  source channel.
REQ-017 SHALL have ports trace_op_o (3), trace_addr_o (ADDR_W), trace_data_o (DATA_W)  output  captured fields.
REQ-018 SHALL have port trace_seq_o  output  32  record sequence number.
REQ-019 SHALL have port ovf_o  output  NUM_CH  sticky per-channel overflow flag.
REQ-020 SHALL have port drop_cnt_o  output  16  total dropped captures, saturating.

Function
REQ-021 Capture on channel k SHALL occur at a clock edge where ch_req_valid_i[k] & ch_req_allowIn_i[k] & trace_en_i.
REQ-022 Captured address SHALL be ch_req_addr_i with bits [LINE_OFF-1:0] forced to 0; op and data captured unmodified.
REQ-023 Each channel SHALL own a DEPTH-entry FIFO; capture writes it, same-edge multi-channel captures all accepted independently.
REQ-024 FIFO full with no same-edge pop: capture dropped, ovf_o[k] set (stays set until reset), drop_cnt_o +1, saturating at 0xFFFF.
REQ-025 FIFO full with same-edge pop: capture SHALL be accepted, no drop.
REQ-026 Multiple same-edge drops SHALL increment drop_cnt_o by the number of dropped captures (saturating).
REQ-027 Output stage SHALL be a single register; it loads when empty or when trace_valid_o & trace_ready_i.
REQ-028 Load source SHALL be chosen round-robin among non-empty FIFOs, starting at channel after the last granted; pointer starts at 0.
REQ-029 Latency: capture at edge E SHALL give trace_valid_o high after edge E+1 at earliest (empty FIFOs, idle output).
REQ-030 trace_valid_o and all trace_* fields SHALL stay stable while trace_valid_o & !trace_ready_i.
REQ-031 trace_seq_o SHALL be 0 for the first record after reset, +1 per loaded record, wrapping 0xFFFFFFFF -> 0.
REQ-032 Full throughput: one record per cycle SHALL be sustained with trace_ready_i held high.
REQ-033 Deasserting trace_en_i SHALL NOT flush FIFOs; queued records still drain.

Reset
REQ-034 While rst is high: trace_valid_o=0, trace_ch_o/op/addr/data=0, trace_seq_o=0, ovf_o=0, drop_cnt_o=0, all FIFOs empty, RR pointer=0.
REQ-035 Reset mid-operation SHALL discard all queued and presented records; first record after release has seq 0.

Structure
REQ-036 Package mcash_tracer_pkg SHALL hold the trace record struct (ch, op, addr, data), the op width constant (3) and the drop counter width (16).
REQ-037 Per-channel FIFO SHALL be sub-module mcash_sync_fifo (parametrised width/depth, push/pop/full/empty, async active-high reset), instantiated NUM_CH times.

Verification
REQ-038 Single capture ch2, addr 0x1234_5678, op 3, data 0xDEAD -> one record ch=2, addr 0x1234_5670, op 3, seq 0, valid two edges after capture.
REQ-039 Same-edge captures ch0..ch3, ready high -> records emitted in order ch0,ch1,ch2,ch3, seq 0..3, back-to-back cycles.
REQ-040 Ready low, 10 captures on ch1 with DEPTH=8 -> 1 in output reg + 8 queued, 1 dropped, ovf_o=0b0010, drop_cnt_o=1.
REQ-041 Ready toggled 1/0 each cycle during continuous ch0+ch1 traffic -> fields stable while stalled, no loss, seq contiguous.
REQ-042 Preload seq to 0xFFFFFFFF via force, emit 2 records -> seq 0xFFFFFFFF then 0x0.
REQ-043 Assert rst with 5 records queued -> trace_valid_o=0 immediately, ovf/drop cleared, next capture emits seq 0.
